// File: rtl/uart_ctrl_if.sv
// Wishbone classic link between uart_ctrl (master) and the UART register port (slave).
interface uart_ctrl_if;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/uart_ctrl.sv
// Wishbone-master sequencer: programs a uart_top, then services tx/rx byte streams by polling LSR.
// Optional ack watchdog and bus_err port: define UART_CTRL_TIMEOUT_EN.
module uart_ctrl #(
  parameter logic [15:0] DIVISOR  = 16'd2,
  parameter logic [7:0]  LCR_CFG  = 8'h1B,
  parameter logic [7:0]  FCR_CFG  = 8'hC7,
  parameter logic [7:0]  IER_CFG  = 8'h00,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_ctrl_if.master wb,
  input  logic        restart,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        init_done,
  output logic [3:0]  lsr_err
`ifdef UART_CTRL_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);

  localparam logic [4:0] REG_RB = 5'd0;
  localparam logic [4:0] REG_IE = 5'd1;
  localparam logic [4:0] REG_FC = 5'd2;
  localparam logic [4:0] REG_LC = 5'd3;
  localparam logic [4:0] REG_LS = 5'd5;
  localparam logic [4:0] TX_CREDIT = 5'(TX_DEPTH);

  typedef enum logic [3:0] {
    I_LCRD, I_DL1, I_DL2, I_LCR, I_FCR, I_IER, IDLE, POLL, TX, RX
  } state_t;

  state_t     state;
  logic [4:0] credit;
  logic       dr;
  logic       rr_rx;
  logic       restart_pend;
  logic       ack;
  logic [7:0] rd_byte;
  logic       tx_elig;
  logic       rx_elig;
`ifdef UART_CTRL_TIMEOUT_EN
  logic [7:0] wdog;
`endif

  // Next access to launch from an idle bus cycle.
  logic       l_go;
  logic       l_honour;
  state_t     l_state;
  logic [4:0] l_adr;
  logic       l_we;
  logic [7:0] l_byte;

  always_comb begin
    ack     = wb.wb_stb_o & wb.wb_ack_i;
    rd_byte = wb.wb_dat_i[{wb.wb_adr_o[1:0], 3'b000} +: 8];
    tx_elig = tx_valid && (credit != 5'd0);
    rx_elig = dr && !rx_valid;
    // Handshake coincides with the ack cycle, so this output follows ack directly.
    tx_ready = (state == TX) && ack;
  end

  always_comb begin
    l_go     = 1'b0;
    l_honour = 1'b0;
    l_state  = state;
    l_adr    = REG_LS;
    l_we     = 1'b0;
    l_byte   = '0;
    if (!wb.wb_stb_o) begin
      case (state)
        I_LCRD: begin l_go = 1'b1; l_adr = REG_LC; l_we = 1'b1; l_byte = LCR_CFG | 8'h80; end
        I_DL1:  begin l_go = 1'b1; l_adr = REG_RB; l_we = 1'b1; l_byte = DIVISOR[7:0];    end
        I_DL2:  begin l_go = 1'b1; l_adr = REG_IE; l_we = 1'b1; l_byte = DIVISOR[15:8];   end
        I_LCR:  begin l_go = 1'b1; l_adr = REG_LC; l_we = 1'b1; l_byte = LCR_CFG;         end
        I_FCR:  begin l_go = 1'b1; l_adr = REG_FC; l_we = 1'b1; l_byte = FCR_CFG;         end
        I_IER:  begin l_go = 1'b1; l_adr = REG_IE; l_we = 1'b1; l_byte = IER_CFG;         end
        IDLE: begin
          if (restart_pend) begin
            l_honour = 1'b1;
            l_state  = I_LCRD;
          end else if (tx_elig && (!rx_elig || !rr_rx)) begin
            l_go = 1'b1; l_state = TX; l_adr = REG_RB; l_we = 1'b1; l_byte = tx_data;
          end else if (rx_elig) begin
            l_go = 1'b1; l_state = RX; l_adr = REG_RB;
          end else begin
            l_go = 1'b1; l_state = POLL; l_adr = REG_LS;
          end
        end
        default: l_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= I_LCRD;
      wb.wb_cyc_o  <= 1'b0;
      wb.wb_stb_o  <= 1'b0;
      wb.wb_we_o   <= 1'b0;
      wb.wb_adr_o  <= '0;
      wb.wb_dat_o  <= '0;
      wb.wb_sel_o  <= '0;
      credit       <= '0;
      dr           <= 1'b0;
      rr_rx        <= 1'b1;
      restart_pend <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      init_done    <= 1'b0;
      lsr_err      <= '0;
`ifdef UART_CTRL_TIMEOUT_EN
      bus_err      <= 1'b0;
      wdog         <= '0;
`endif
    end else begin
      if (restart) restart_pend <= 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (wb.wb_stb_o) begin
        if (ack) begin
          wb.wb_cyc_o <= 1'b0;
          wb.wb_stb_o <= 1'b0;
          wb.wb_we_o  <= 1'b0;
          wb.wb_adr_o <= '0;
          wb.wb_dat_o <= '0;
          wb.wb_sel_o <= '0;
`ifdef UART_CTRL_TIMEOUT_EN
          wdog        <= '0;
`endif
          case (state)
            I_LCRD: state <= I_DL1;
            I_DL1:  state <= I_DL2;
            I_DL2:  state <= I_LCR;
            I_LCR:  state <= I_FCR;
            I_FCR:  state <= I_IER;
            I_IER: begin
              credit    <= '0;
              init_done <= 1'b1;
              state     <= IDLE;
            end
            POLL: begin
              if (rd_byte[5]) credit <= TX_CREDIT;
              dr      <= rd_byte[0];
              lsr_err <= lsr_err | rd_byte[4:1];
              state   <= IDLE;
            end
            TX: begin
              if (credit != 5'd0) credit <= credit - 5'd1;
              state <= IDLE;
            end
            RX: begin
              rx_data  <= rd_byte;
              rx_valid <= 1'b1;
              dr       <= 1'b0;
              state    <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
`ifdef UART_CTRL_TIMEOUT_EN
        else if (wdog == 8'd254) begin
          // 255th cycle without ack: abandon the access with no stream side effects.
          wb.wb_cyc_o <= 1'b0;
          wb.wb_stb_o <= 1'b0;
          wb.wb_we_o  <= 1'b0;
          wb.wb_adr_o <= '0;
          wb.wb_dat_o <= '0;
          wb.wb_sel_o <= '0;
          wdog        <= '0;
          bus_err     <= 1'b1;
          state       <= IDLE;
        end else begin
          wdog <= wdog + 8'd1;
        end
`endif
      end else begin
        state <= l_state;
        if (l_honour) begin
          init_done    <= 1'b0;
          restart_pend <= restart;
          lsr_err      <= '0;
          rx_valid     <= 1'b0;
          dr           <= 1'b0;
          credit       <= '0;
`ifdef UART_CTRL_TIMEOUT_EN
          bus_err      <= 1'b0;
`endif
        end else if (l_go) begin
          wb.wb_cyc_o <= 1'b1;
          wb.wb_stb_o <= 1'b1;
          wb.wb_we_o  <= l_we;
          wb.wb_adr_o <= l_adr;
          wb.wb_sel_o <= 4'b0001 << l_adr[1:0];
          wb.wb_dat_o <= 32'(l_byte) << {l_adr[1:0], 3'b000};
          if (l_state == TX || l_state == RX) rr_rx <= (l_state == TX);
        end
      end
    end
  end

endmodule
